ctrl_uart_rx: RTL and testbench
===============================

// Module: ctrl_uart_rx
// PURPOSE
//  Serial UART receiver with RX FIFO for the control block; sits between the uart_rxd pin and ctrl_regs.
//  Provides the UART_RX data register (0x00800010) and the RX bits of the UART_STAT register (0x00800014).
//  Frame format: 8N1, LSB first, 16x oversampling from a fixed clock prescaler.
// PARAMETERS
//  CLK_DIV   27  clk cycles per 1/16 bit tick (50 MHz / (115200*16))
//  FIFO_AW   4   FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//  clk        in   1          system clock (ctrl_top clk)
//  rst_n      in   1          asynchronous active-low reset
//  rxd        in   1          serial input, async to clk, idle high
//  rx_rd      in   1          1-cycle pop strobe from ctrl_regs (read of UART_RX)
//  err_clr    in   1          1-cycle clear of sticky error flags
//  rx_dat     out  8          FIFO head byte (show-ahead), valid when !rx_empty
//  rx_empty   out  1          FIFO empty
//  rx_full    out  1          FIFO full
//  rx_cnt     out  FIFO_AW+1  FIFO fill level
//  rx_ovr     out  1          sticky: byte dropped because FIFO full
//  rx_ferr    out  1          sticky: stop bit sampled low
//  rx_perr    out  1          sticky: parity error (0 when parity disabled)
// BEHAVIOUR
//  - Reset: rx_dat=0, rx_empty=1, rx_full=0, rx_cnt=0, sticky flags 0, FSM=IDLE, sync flops=1, pointers 0.
//  - rxd passes a 2-FF synchronizer before any use; prescaler free-runs, emits 1-clk tick every CLK_DIV clks.
//  - Per-frame 4-bit tick counter restarts at start-bit detection; sample point = tick 8 of each bit.
//  - FSM:
//    IDLE : synced rxd==0 -> START, clear tick counter.
//    START: at tick 8 rxd==1 -> IDLE (glitch, nothing stored); rxd==0 -> DATA, bit index 0.
//    DATA : every 16 ticks shift rxd into shift reg at bit[idx], LSB first; after idx 7 -> PARITY/STOP.
//    PARITY (macro only): 16 ticks later sample parity bit -> STOP.
//    STOP : 16 ticks later sample rxd. 1: push byte, -> IDLE.
//           0: set rx_ferr, discard byte, -> BRK; BRK waits for rxd==1 then -> IDLE.
//  - Push: FIFO write 1 clk after stop sample; rx_empty/rx_cnt update on the following clk edge.
//  - Pop: rx_rd && !rx_empty advances read pointer; rx_dat shows next entry next cycle.
//  - rx_rd while empty: ignored, no pointer or count change, no error.
//  - Push while full and no rx_rd: byte dropped, rx_ovr set, FIFO contents unchanged.
//  - Push while full with rx_rd same cycle: both happen, count stays full, no overrun.
//  - Push and pop same cycle, non-full: count unchanged.
//  - Pointers wrap modulo 2**FIFO_AW; rx_cnt is FIFO_AW+1 bits, full when rx_cnt == 2**FIFO_AW.
//  - err_clr clears all sticky flags; a set event in the same cycle wins (flag stays 1).
//  - Reset mid-frame: frame abandoned, FIFO emptied, FSM IDLE; next full frame is received normally.
// CONFIGURATION
//  CTRL_UART_RX_PARITY_EN defined: frame 8E1, PARITY state active; even parity checked.
//    On mismatch, set rx_perr and still push the byte if the stop bit is valid.
//  Not defined: no PARITY state, frame 8N1, rx_perr tied 0.
// TESTING
//  1. Send 0xAB at 115200 (CLK_DIV=27, 20 ns clk) -> rx_empty falls, rx_dat=0xAB, rx_cnt=1; rx_rd -> rx_empty=1.
//  2. 4-tick low pulse on rxd -> FSM returns IDLE; rx_empty stays 1, no flags.
//  3. Frame 0x55 with stop bit forced 0 -> rx_ferr=1, rx_cnt=0; err_clr -> rx_ferr=0.
//  4. 17 bytes 0x00..0x10 with no reads (FIFO_AW=4) -> rx_full=1, rx_cnt=16, rx_ovr=1; reads return 0x00..0x0F.
//  5. Assert rst_n=0 during DATA bit 3, then send 0x3C -> only 0x3C in FIFO, flags 0.
//  6. CTRL_UART_RX_PARITY_EN: 0x07 with odd parity bit -> rx_perr=1, rx_dat=0x07; correct parity -> no flag.

Source files
------------

// File: rtl/ctrl_uart_rx_if.sv
// ctrl_uart_rx_if: pin and ctrl_regs side signals of the UART receiver.
// slave = receiver, master = pin driver / register block.
interface ctrl_uart_rx_if #(
  parameter int FIFO_AW = 4
);
  logic             rxd;
  logic             rx_rd;
  logic             err_clr;
  logic [7:0]       rx_dat;
  logic             rx_empty;
  logic             rx_full;
  logic [FIFO_AW:0] rx_cnt;
  logic             rx_ovr;
  logic             rx_ferr;
  logic             rx_perr;

  modport master (
    output rxd, rx_rd, err_clr,
    input  rx_dat, rx_empty, rx_full, rx_cnt,
    input  rx_ovr, rx_ferr, rx_perr
  );

  modport slave (
    input  rxd, rx_rd, err_clr,
    output rx_dat, rx_empty, rx_full, rx_cnt,
    output rx_ovr, rx_ferr, rx_perr
  );
endinterface

// File: rtl/ctrl_uart_rx.sv
// ctrl_uart_rx: 16x oversampled 8N1 UART receiver with show-ahead RX FIFO.
// Define CTRL_UART_RX_PARITY_EN for 8E1 frames with even-parity checking.
module ctrl_uart_rx #(
  parameter int CLK_DIV = 27,
  parameter int FIFO_AW = 4
) (
  input logic           clk,
  input logic           rst_n,
  ctrl_uart_rx_if.slave bus
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0]      PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]      PRE_ONE = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
  localparam logic [FIFO_AW:0]   CNT_ONE = 1;
  localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef CTRL_UART_RX_PARITY_EN
    S_PAR,
`endif
    S_STOP,
    S_BRK
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic [PW-1:0] r_pre;
  state_t        r_state;
  logic [3:0]    r_tcnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_push;
  logic          r_ferr;
  logic          w_rxd;
  logic          w_tick;
  logic          w_samp;

  assign w_rxd  = r_sync2;
  assign w_tick = (r_pre == PRE_MAX);
  assign w_samp = w_tick && (r_tcnt == 4'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_pre   <= '0;
    end else begin
      r_sync1 <= bus.rxd;
      r_sync2 <= r_sync1;
      r_pre   <= w_tick ? '0 : r_pre + PRE_ONE;
    end
  end

`ifdef CTRL_UART_RX_PARITY_EN
  logic r_perr;
`endif

  // Sample point is the tick that moves r_tcnt from 7 to 8.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_push  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef CTRL_UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_push <= 1'b0;
      if (bus.err_clr) begin
        r_ferr <= 1'b0;
`ifdef CTRL_UART_RX_PARITY_EN
        r_perr <= 1'b0;
`endif
      end
      if (w_tick) r_tcnt <= r_tcnt + 4'd1;
      unique case (r_state)
        S_IDLE: begin
          if (!w_rxd) begin
            r_state <= S_START;
            r_tcnt  <= '0;
          end
        end
        S_START: begin
          if (w_samp) begin
            r_idx   <= '0;
            r_state <= w_rxd ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_samp) begin
            r_shift[r_idx] <= w_rxd;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
`ifdef CTRL_UART_RX_PARITY_EN
              r_state <= S_PAR;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
`ifdef CTRL_UART_RX_PARITY_EN
        S_PAR: begin
          if (w_samp) begin
            if (w_rxd != ^r_shift) r_perr <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_samp) begin
            if (w_rxd) begin
              r_push  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BRK;
            end
          end
        end
        S_BRK: begin
          if (w_rxd) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp;
  logic [FIFO_AW-1:0] r_rp;
  logic [FIFO_AW:0]   r_cnt;
  logic               r_ovr;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_MAX);
  assign w_pop   = bus.rx_rd && !w_empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_wr    = r_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= r_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + PTR_ONE;
      if (w_pop) r_rp <= r_rp + PTR_ONE;
      if (w_wr && !w_pop)      r_cnt <= r_cnt + CNT_ONE;
      else if (!w_wr && w_pop) r_cnt <= r_cnt - CNT_ONE;
      if (bus.err_clr) r_ovr <= 1'b0;
      if (r_push && !w_wr) r_ovr <= 1'b1;
    end
  end

  assign bus.rx_dat   = w_empty ? 8'h00 : r_mem[r_rp];
  assign bus.rx_empty = w_empty;
  assign bus.rx_full  = w_full;
  assign bus.rx_cnt   = r_cnt;
  assign bus.rx_ovr   = r_ovr;
  assign bus.rx_ferr  = r_ferr;
`ifdef CTRL_UART_RX_PARITY_EN
  assign bus.rx_perr  = r_perr;
`else
  assign bus.rx_perr  = 1'b0;
`endif
endmodule

// File: tb/tb_ctrl_uart_rx.sv
// tb_ctrl_uart_rx: randomized frames checked against a queue model
// of the RX FIFO and its sticky flags.
module tb_ctrl_uart_rx;
  localparam int CD    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int BIT   = 16 * CD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  ctrl_uart_rx_if #(.FIFO_AW(AW)) bus();

  ctrl_uart_rx #(
    .CLK_DIV(CD),
    .FIFO_AW(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned q[$];
  bit m_ovr, m_ferr, m_perr;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(string tag);
    chk({tag, "_empty"}, 32'(bus.rx_empty), 32'(q.size() == 0));
    chk({tag, "_full"},  32'(bus.rx_full),  32'(q.size() == DEPTH));
    chk({tag, "_cnt"},   32'(bus.rx_cnt),   32'(q.size()));
    chk({tag, "_ovr"},   32'(bus.rx_ovr),   32'(m_ovr));
    chk({tag, "_ferr"},  32'(bus.rx_ferr),  32'(m_ferr));
    chk({tag, "_perr"},  32'(bus.rx_perr),  32'(m_perr));
    if (q.size() != 0) chk({tag, "_dat"}, 32'(bus.rx_dat), 32'(q[0]));
  endtask

  task automatic send_bit(logic b);
    bus.rxd = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(byte unsigned d, bit stop, bit badpar);
    logic [7:0] v;
    v = d;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
`ifdef CTRL_UART_RX_PARITY_EN
    send_bit((^v) ^ badpar);
    if (badpar) m_perr = 1'b1;
`endif
    send_bit(stop);
    if (!stop)                m_ferr = 1'b1;
    else if (q.size() < DEPTH) q.push_back(d);
    else                      m_ovr = 1'b1;
    bus.rxd = 1'b1;
    repeat ($urandom_range(1, 12)) @(negedge clk);
  endtask

  task automatic pop(string tag);
    if (q.size() != 0) chk({tag, "_head"}, 32'(bus.rx_dat), 32'(q[0]));
    bus.rx_rd = 1'b1;
    @(negedge clk);
    bus.rx_rd = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    @(negedge clk);
  endtask

  task automatic clr_err();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    byte unsigned d;
    bus.rxd     = 1'b1;
    bus.rx_rd   = 1'b0;
    bus.err_clr = 1'b0;
    repeat (5) @(negedge clk);
    check_state("reset");
    chk("reset_dat", 32'(bus.rx_dat), 32'h0);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);

    send_frame(8'hAB, 1'b1, 1'b0);
    check_state("ab");
    chk("ab_dat", 32'(bus.rx_dat), 32'hAB);
    pop("ab");
    check_state("ab_pop");

    bus.rxd = 1'b0;
    repeat (4 * CD) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check_state("glitch");

    pop("rd_empty");
    check_state("rd_empty");

    send_frame(8'h55, 1'b0, 1'b0);
    check_state("ferr");
    clr_err();
    check_state("ferr_clr");

    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0);
    check_state("ovf");
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_rd", 32'(bus.rx_dat), 32'(i));
      pop("ovf");
    end
    check_state("ovf_drain");
    clr_err();

    send_frame(8'h99, 1'b1, 1'b0);
    d = 8'($urandom);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    bus.rxd = d[3];
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    repeat (3) @(negedge clk);
    check_state("rst_mid");
    bus.rxd = 1'b1;
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b0);
    check_state("after_rst");
    chk("after_rst_dat", 32'(bus.rx_dat), 32'h3C);
    pop("after_rst");

`ifdef CTRL_UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    check_state("par_bad");
    chk("par_bad_dat", 32'(bus.rx_dat), 32'h07);
    pop("par_bad");
    clr_err();
    send_frame(8'h07, 1'b1, 1'b0);
    check_state("par_ok");
    pop("par_ok");
`endif

    for (int n = 0; n < 40; n++) begin
      send_frame(8'($urandom), 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        int k = $urandom_range(1, q.size() + 1);
        for (int j = 0; j < k; j++) pop("rnd");
      end
      if ($urandom_range(0, 7) == 0) clr_err();
      check_state("rnd");
    end
    while (q.size() != 0) pop("drain");
    check_state("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
